// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encoding,
// protocol byte constants and the frame parity rule.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam int         FRAME_BITS = 11;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronises the asynchronous PS/2 lines, debounces ps2_clk and emits a
// one-cycle pulse on each filtered falling edge, with the data bit aligned to it.
module ps2_input_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall_edge,
    output logic data_bit
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_level;
    logic [CW-1:0] run_cnt;

    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // blocking here would collapse the two synchroniser stages into one.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_level <= 1'b1;
            run_cnt   <= '0;
            fall_edge <= 1'b0;
            data_bit  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            data_bit  <= data_sync[1];
            fall_edge <= 1'b0;
            // The level flips only after FILTER_LEN consecutive samples disagree with it.
            if (clk_sync[1] == clk_level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                clk_level <= clk_sync[1];
                run_cnt   <= '0;
                fall_edge <= clk_level;
            end else begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: frames bytes from the filtered clock/data, keeps a
// four-byte history and flags make/break codes, with a mid-frame timeout.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] keycode,
    output logic        byte_valid,
    output logic        key_down,
    output logic        key_up,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          fall_edge;
    logic          data_bit;
    ps2_state_t    state_q, state_d;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          parity_q;
    logic [TW-1:0] to_cnt_q;
    logic          break_q;
    logic          accept;
    logic          discard;
    logic          timeout;

    ps2_input_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall_edge(fall_edge),
        .data_bit (data_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held and infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        discard = 1'b0;
        timeout = (state_q != ST_IDLE) && !fall_edge && (to_cnt_q >= TW'(TIMEOUT_CYCLES));
        if (timeout) begin
            state_d = ST_IDLE;
            discard = 1'b1;
        end else if (fall_edge) begin
            case (state_q)
                ST_IDLE:   if (!data_bit) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_bit && odd_parity_ok(shift_q, parity_q)) accept  = 1'b1;
                    else                                              discard = 1'b1;
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            parity_q   <= 1'b0;
            to_cnt_q   <= '0;
            break_q    <= 1'b0;
            keycode    <= '0;
            byte_valid <= 1'b0;
            key_down   <= 1'b0;
            key_up     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= accept;
            key_down   <= accept && (shift_q != BREAK_CODE) && !break_q;
            key_up     <= accept && (shift_q != BREAK_CODE) && break_q;
            frame_err  <= discard;

            if (accept) begin
                keycode <= {keycode[23:0], shift_q};
                if (shift_q == BREAK_CODE)    break_q <= 1'b1;
                else if (shift_q != EXT_CODE) break_q <= 1'b0;
            end

            // Counts idle cycles between edges mid-frame; saturates at the limit.
            if (state_d == ST_IDLE || fall_edge)
                to_cnt_q <= '0;
            else if (to_cnt_q != TW'(TIMEOUT_CYCLES))
                to_cnt_q <= to_cnt_q + TW'(1);

            if (fall_edge) begin
                case (state_q)
                    ST_IDLE: if (!data_bit) bit_cnt_q <= '0;
                    ST_DATA: begin
                        shift_q   <= {data_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    ST_PARITY: parity_q <= data_bit;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: scenario tasks plus randomized frames
// compared against a byte-history reference model.
module tb_ps2_keycode_rx;
    import ps2_pkg::*;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] keycode;
    logic        byte_valid;
    logic        key_down;
    logic        key_up;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned last_fall_cyc = 0;

    typedef struct packed {
        logic        bv;
        logic        kd;
        logic        ku;
        logic        fe;
        logic [31:0] kc;
    } ev_t;

    ev_t         ev_q[$];
    int unsigned ev_cyc_q[$];
    logic [7:0]  hist[$];

    ps2_keycode_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .byte_valid(byte_valid),
        .key_down  (key_down),
        .key_up    (key_up),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (byte_valid || key_down || key_up || frame_err) begin
            ev_q.push_back({byte_valid, key_down, key_up, frame_err, keycode});
            ev_cyc_q.push_back(cyc);
        end
    end

    // Reference model: keycode is the last four accepted bytes; the break state
    // is whether the most recent accepted non-E0 byte was F0.
    function automatic logic [31:0] exp_keycode();
        logic [31:0] kc = '0;
        for (int i = 0; i < 4; i++)
            if (hist.size() > i) kc[8*i +: 8] = hist[hist.size() - 1 - i];
        return kc;
    endfunction

    function automatic logic exp_break();
        for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i] != 8'hE0) return hist[i] == 8'hF0;
        return 1'b0;
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par_ok,
                                               input logic stop_ok);
        logic p;
        p = ~(^b);
        if (!par_ok) p = ~p;
        return {stop_ok, p, b, 1'b0};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_edges(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cycles(HALF);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic get_event(input int budget, output logic found, output ev_t ev,
                             output int unsigned at);
        for (int i = 0; i < budget && ev_q.size() == 0; i++) wait_cycles(1);
        found = ev_q.size() > 0;
        ev    = '0;
        at    = 0;
        if (found) begin
            ev = ev_q.pop_front();
            at = ev_cyc_q.pop_front();
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input logic par_ok, input logic stop_ok,
                             output ev_t got, output ev_t want, output int unsigned lat);
        logic        found;
        int unsigned at;
        send_edges(make_frame(b, par_ok, stop_ok), FRAME_BITS);
        want = '0;
        if (par_ok && stop_ok) begin
            want.bv = 1'b1;
            want.kd = (b != 8'hF0) && !exp_break();
            want.ku = (b != 8'hF0) && exp_break();
            hist.push_back(b);
        end else begin
            want.fe = 1'b1;
        end
        want.kc = exp_keycode();
        get_event(200, found, got, at);
        lat = found ? at - last_fall_cyc : 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(5);
        checks++;
        if ({keycode, byte_valid, key_down, key_up, frame_err} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h",
                     {keycode, byte_valid, key_down, key_up, frame_err}, 36'h0);
        end
        reset = 1'b0;
        wait_cycles(30);
        checks++;
        if (ev_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_quiet: got %0d events want 0", ev_q.size());
        end
    endtask

    task automatic test_single_key();
        ev_t got, want;
        int unsigned lat;
        run_frame(8'h1D, 1'b1, 1'b1, got, want, lat);
        checks++;
        if (got !== want || want !== {4'b1100, 32'h0000_001D}) begin
            errors++;
            $display("FAIL single_1D: got %h want %h", got, {4'b1100, 32'h0000_001D});
        end
        checks++;
        if (lat > FILTER_LEN + 4) begin
            errors++;
            $display("FAIL latency: got %0d cycles want <= %0d", lat, FILTER_LEN + 4);
        end
    endtask

    task automatic test_break_sequence();
        ev_t got, want;
        int unsigned lat;
        run_frame(8'hF0, 1'b1, 1'b1, got, want, lat);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL break_F0: got %h want %h", got, want);
        end
        run_frame(8'h1D, 1'b1, 1'b1, got, want, lat);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL break_1D: got %h want %h", got, want);
        end
        checks++;
        if (keycode !== 32'h001D_F01D) begin
            errors++;
            $display("FAIL break_keycode: got %h want %h", keycode, 32'h001D_F01D);
        end
    endtask

    task automatic test_frame_errors();
        ev_t got, want;
        int unsigned lat;
        run_frame(8'h1D, 1'b0, 1'b1, got, want, lat);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL bad_parity: got %h want %h", got, want);
        end
        run_frame(8'h2A, 1'b1, 1'b0, got, want, lat);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL bad_stop: got %h want %h", got, want);
        end
        checks++;
        if (keycode !== exp_keycode()) begin
            errors++;
            $display("FAIL err_keycode_kept: got %h want %h", keycode, exp_keycode());
        end
    endtask

    task automatic test_timeout();
        ev_t got, want;
        logic found;
        int unsigned at, lat;
        send_edges(make_frame(8'h55, 1'b1, 1'b1), 5);
        get_event(TIMEOUT_CYCLES + 500, found, got, at);
        want = {4'b0001, exp_keycode()};
        checks++;
        if (!found || got !== want) begin
            errors++;
            $display("FAIL timeout: got %h (found=%0b) want %h", got, found, want);
        end
        run_frame(8'h23, 1'b1, 1'b1, got, want, lat);
        checks++;
        if (got !== want || keycode[7:0] !== 8'h23) begin
            errors++;
            $display("FAIL after_timeout_23: got %h want %h", got, want);
        end
    endtask

    task automatic test_glitch_and_reset();
        ev_t got, want;
        int unsigned lat;
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
        wait_cycles(100);
        checks++;
        if (ev_q.size() !== 0) begin
            errors++;
            $display("FAIL glitch: got %0d events want 0", ev_q.size());
        end
        send_edges(make_frame(8'h1C, 1'b1, 1'b1), 5);
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        hist.delete();
        wait_cycles(TIMEOUT_CYCLES / 4);
        checks++;
        if (ev_q.size() !== 0 || keycode !== 32'h0) begin
            errors++;
            $display("FAIL midframe_reset: got %0d events keycode %h want 0 events keycode 0",
                     ev_q.size(), keycode);
        end
        run_frame(8'h1C, 1'b1, 1'b1, got, want, lat);
        checks++;
        if (got !== want || keycode !== 32'h0000_001C) begin
            errors++;
            $display("FAIL fresh_1C: got %h want %h", got, {4'b1100, 32'h0000_001C});
        end
    endtask

    task automatic test_back_to_back();
        ev_t got, want;
        int unsigned lat;
        logic [7:0] b;
        int r, e;
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 99);
            b = (r < 20) ? 8'hF0 : (r < 30) ? 8'hE0 : 8'($urandom);
            e = $urandom_range(0, 9);
            run_frame(b, e != 0, e != 1, got, want, lat);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random_%0d byte %h: got %h want %h", n, b, got, want);
            end
            if (want.bv) begin
                checks++;
                if (lat > FILTER_LEN + 4) begin
                    errors++;
                    $display("FAIL random_latency_%0d: got %0d want <= %0d", n, lat, FILTER_LEN + 4);
                end
            end
        end
        wait_cycles(50);
        checks++;
        if (ev_q.size() !== 0) begin
            errors++;
            $display("FAIL extra_events: got %0d want 0", ev_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_break_sequence();
        test_frame_errors();
        test_timeout();
        test_glitch_and_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation exceeded %0d cycles", 90000);
        $fatal(1, "watchdog");
    end

endmodule
